truncar_sat: RTL and testbench
==============================

TRUNCAR_SAT -- requirements
Module: truncar_sat

Interface
REQ-001 The block SHALL take `N (default per constantes.h) as the Q-format word width, where `N = 1 + `M + `F.
REQ-002 The block SHALL take `M (default per constantes.h) as the integer bit count of the N-bit format.
REQ-003 The block SHALL take `F (default per constantes.h) as the fractional bit count of the N-bit format; the bench build SHALL use N=16, M=7, F=8.
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1, single clock; all state on the rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- in_valid, in, 1, input sample present.
- in_ready, out, 1, block accepts the sample this cycle.
- entrada, in, 2N signed, product-format sample: 2M+2 integer/sign bits, 2F fraction bits.
- round_en, in, 1, sampled together with entrada; 1 = round half-up, 0 = truncate.
- out_valid, out, 1, salida valid.
- out_ready, in, 1, downstream accepts.
- salida, out, N signed, N-bit Q-format result.
- sat, out, 1, salida was clipped; aligned with salida.
- sat_count, out, 16, count of saturated samples delivered.
- clr_count, in, 1, synchronous clear of sat_count.

Function
REQ-005 A transfer SHALL occur on a rising edge with in_valid&&in_ready (input side) or with out_valid&&out_ready (output side).
REQ-006 The datapath SHALL be a two-stage pipeline: S1 holds the rounded sum and flags; S2 holds salida and sat.
REQ-007 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready stays high.
REQ-008 S2 SHALL load when it is empty or emptying (out_ready high); S1 SHALL load when it is empty or S2 loads.
REQ-009 in_ready SHALL equal !v1 || !v2 || out_ready; it SHALL be purely combinational from state and out_ready, and in_valid SHALL have no combinational path to it.
REQ-010 Throughput SHALL be one sample per cycle with no bubbles while out_ready is high; under backpressure the pipeline SHALL hold two samples, drop nothing, and preserve order.
REQ-011 salida, sat and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-012 The rounding stage SHALL form r = sext(entrada, 2N+1) + (round_en ? 2^(F-1) : 0) in 2N+1 bits, so no wrap occurs.
REQ-013 If r[2N:F+N-1] are all equal, the output SHALL be salida = r[F+N-1:F] with sat = 0.
REQ-014 Otherwise the output SHALL saturate with sat = 1: salida = 0 followed by N-1 ones if r[2N] = 0, and 1 followed by N-1 zeros if r[2N] = 1.
REQ-015 Any value produced by sign-extending an N-bit Q-format word into product format SHALL pass through unchanged with sat = 0, for both round_en values.
REQ-016 sat_count SHALL increment by 1 on each output transfer with sat = 1 and SHALL stick at 16'hFFFF.
REQ-017 clr_count SHALL clear sat_count to 0 and SHALL win over a simultaneous increment.

Reset
REQ-018 While rst_n = 0 the block SHALL asynchronously force out_valid = 0, internal S1/S2 valids = 0, salida = 0, sat = 0 and sat_count = 0.
REQ-019 in_ready SHALL read 1 in the first cycle after rst_n deasserts.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight samples, with no partial output afterwards.
REQ-021 Release of rst_n SHALL be synchronized externally; no transfer SHALL be accepted on the deasserting edge.

Verification
REQ-022 The bench SHALL check rounding: entrada=32'h00012380 with round_en=1 -> salida=16'h0124, sat=0; with round_en=0 -> salida=16'h0123, sat=0.
REQ-023 The bench SHALL check saturation: 32'h01000000 -> 16'h7FFF, sat=1; 32'hFF000000 -> 16'h8000, sat=1; sat_count ends at 2.
REQ-024 The bench SHALL check round-induced overflow: 32'h007FFF80 with round_en=1 -> 16'h7FFF, sat=1; with round_en=0 -> 16'h7FFF, sat=0.
REQ-025 The bench SHALL check round-trip: 32'hFF800100 (sign-extended 16'h8001) -> 16'h8001, sat=0, for both round_en values.
REQ-026 The bench SHALL check backpressure: out_ready=0 for 4 cycles while streaming A, B, C -> A and B are accepted, in_ready=0 with C pending, salida holds A; after out_ready=1, outputs are A, B, C in consecutive cycles.
REQ-027 The bench SHALL check counter and reset: 65536 saturated transfers -> sat_count=16'hFFFF; clr_count with a saturated transfer in the same cycle -> 0; rst_n pulse with two samples in flight -> no outputs afterwards, sat_count=0.

Source files
------------

// File: rtl/truncar_sat.sv
// Two-stage rounding/saturating narrower: product-format sample (2N bits, 2F fraction)
// to N-bit Q(M.F). Stage 1 rounds and flags overflow, stage 2 clips and presents.
module truncar_sat #(
  parameter int N = 16,
  parameter int M = 7,
  parameter int F = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [2*N-1:0] entrada,
  input  logic                  round_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [N-1:0]   salida,
  output logic                  sat,
  output logic [15:0]           sat_count,
  input  logic                  clr_count
);

  localparam int RW  = 2*N + 1;
  localparam int TOP = 2*F + M;
  localparam logic [RW-1:0] HALF = RW'(1) << (F-1);

  // valid/ready: a beat moves on a rising edge where valid && ready; valid holds
  // its data stable until accepted, ready never depends on the same-side valid.

  logic [RW-1:0] r_next;
  logic          ovf_next;
  logic          unused_frac;

  logic          v1;
  logic [N-1:0]  hi1;
  logic          neg1;
  logic          ovf1;

  logic          load1;
  logic          load2;

  // One extra bit of headroom means the half-LSB add can never wrap.
  assign r_next      = {entrada[2*N-1], entrada} + (round_en ? HALF : '0);
  assign ovf_next    = !((&r_next[RW-1:TOP]) || !(|r_next[RW-1:TOP]));
  assign unused_frac = ^r_next[F-1:0];

  assign load2    = !out_valid || out_ready;
  assign load1    = !v1 || load2;
  assign in_ready = !v1 || !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      hi1       <= '0;
      neg1      <= 1'b0;
      ovf1      <= 1'b0;
      out_valid <= 1'b0;
      salida    <= '0;
      sat       <= 1'b0;
      sat_count <= '0;
    end else begin
      if (load1) begin
        v1 <= in_valid;
        if (in_valid) begin
          hi1  <= r_next[TOP:F];
          neg1 <= r_next[RW-1];
          ovf1 <= ovf_next;
        end
      end
      if (load2) begin
        out_valid <= v1;
        if (v1) begin
          salida <= ovf1 ? {neg1, {(N-1){!neg1}}} : hi1;
          sat    <= ovf1;
        end
      end
      if (clr_count)
        sat_count <= '0;
      else if (out_valid && out_ready && sat && (sat_count != 16'hFFFF))
        sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_truncar_sat.sv
// Bench for truncar_sat: directed literal cases plus randomized traffic checked
// every cycle against an arithmetic model of round/saturate.
module tb_truncar_sat;

  localparam int N = 16;
  localparam int F = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] entrada;
  logic        round_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] salida;
  logic        sat;
  logic [15:0] sat_count;
  logic        clr_count;

  int total = 0;
  int bad   = 0;

  logic [16:0] exp_q[$];
  int          model_cnt = 0;

  truncar_sat #(.N(16), .M(7), .F(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .entrada(entrada), .round_en(round_en), .out_valid(out_valid),
    .out_ready(out_ready), .salida(salida), .sat(sat),
    .sat_count(sat_count), .clr_count(clr_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    total++;
    bad++;
    $display("FAIL %s (no response within bound)", nm);
  endtask

  // Value-level reference: round half-up, floor to F fraction bits, clip to N-bit range.
  function automatic logic [16:0] model(logic [31:0] e, logic r);
    longint v;
    longint hi;
    longint lo;
    logic [63:0] u;
    hi = (longint'(1) <<< (N-1)) - 1;
    lo = -(longint'(1) <<< (N-1));
    v = longint'($signed(e)) + (r ? (longint'(1) <<< (F-1)) : 0);
    v = v >>> F;
    if (v > hi) return {1'b1, 16'h7FFF};
    if (v < lo) return {1'b1, 16'h8000};
    u = v;
    return {1'b0, u[15:0]};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [15:0] w;
    logic [31:0] base;
    w = 16'($urandom);
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return {{8{w[15]}}, w, 8'h00};
      2: begin
        base = ($urandom_range(0, 1) != 0) ? 32'h007FFF80 : 32'hFF800000;
        return base + 32'($urandom_range(0, 511)) - 32'd256;
      end
      default: return {{12{w[15]}}, w, 4'($urandom)};
    endcase
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic xfer_sat;
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = 0;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_sat_count", sat_count, 0);
      chk("reset_salida_sat", {sat, salida}, 0);
    end else begin
      chk("sat_count", sat_count, model_cnt);
      chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      xfer_sat = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output act=%0h exp=none", {sat, salida});
        end else begin
          chk("salida_sat", {sat, salida}, exp_q[0]);
          if (out_ready) begin
            xfer_sat = exp_q[0][16];
            void'(exp_q.pop_front());
          end
        end
      end
      if (clr_count) model_cnt = 0;
      else if (xfer_sat && model_cnt != 16'hFFFF) model_cnt++;
      if (in_valid && in_ready) exp_q.push_back(model(entrada, round_en));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(logic [31:0] e, logic r);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    entrada  = e;
    round_en = r;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail("send_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_expect(string nm, logic [31:0] e, logic r, logic [15:0] es, logic esat);
    bit got;
    got = 0;
    out_ready = 1'b1;
    send(e, r);
    for (int w = 1; w <= 8; w++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        chk({nm, "_latency"}, w, 2);
        chk({nm, "_out"}, {sat, salida}, {esat, es});
        break;
      end
    end
    if (!got) fail({nm, "_timeout"});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int guard;
    bit acc;
    bit got;

    rst_n = 1'b0; in_valid = 1'b0; entrada = '0; round_en = 1'b0;
    out_ready = 1'b1; clr_count = 1'b0;

    chk("model_pin_round",  model(32'h00012380, 1'b1), 17'h00124);
    chk("model_pin_trunc",  model(32'h00012380, 1'b0), 17'h00123);
    chk("model_pin_ovf",    model(32'h007FFF80, 1'b1), 17'h17FFF);
    chk("model_pin_neg",    model(32'hFF000000, 1'b0), 17'h18000);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    send_expect("sat_pos", 32'h01000000, 1'b0, 16'h7FFF, 1'b1);
    send_expect("sat_neg", 32'hFF000000, 1'b0, 16'h8000, 1'b1);
    @(negedge clk);
    chk("sat_count_two", sat_count, 2);
    @(posedge clk); #1;

    send_expect("round_on",   32'h00012380, 1'b1, 16'h0124, 1'b0);
    send_expect("round_off",  32'h00012380, 1'b0, 16'h0123, 1'b0);
    send_expect("ovf_round",  32'h007FFF80, 1'b1, 16'h7FFF, 1'b1);
    send_expect("ovf_trunc",  32'h007FFF80, 1'b0, 16'h7FFF, 1'b0);
    send_expect("trip_round", 32'hFF800100, 1'b1, 16'h8001, 1'b0);
    send_expect("trip_trunc", 32'hFF800100, 1'b0, 16'h8001, 1'b0);

    // Backpressure: four stalled edges while streaming A, B, C.
    out_ready = 1'b0; in_valid = 1'b1; entrada = 32'h00001200; round_en = 1'b0;
    @(posedge clk); #1 entrada = 32'h00003400;
    @(posedge clk); #1 entrada = 32'h00005600;
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_hold_a0", {out_valid, salida}, {1'b1, 16'h0012});
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_hold_a1", {out_valid, salida}, {1'b1, 16'h0012});
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_a", {out_valid, salida}, {1'b1, 16'h0012});
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out_b", {out_valid, salida}, {1'b1, 16'h0034});
    @(negedge clk);
    chk("bp_out_c", {out_valid, salida}, {1'b1, 16'h0056});
    @(posedge clk); #1;
    drain();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        entrada  = rand_word();
        round_en = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr_count = ($urandom_range(0, 199) == 0);
    end
    clr_count = 1'b0;
    drain();
    chk("random_drained", exp_q.size(), 0);

    // Counter saturation.
    clr_count = 1'b1;
    @(posedge clk); #1 clr_count = 1'b0;
    in_valid = 1'b1; entrada = 32'h01000000;
    cnt = 0; guard = 0;
    while (cnt < 65536 && guard < 70000) begin
      @(negedge clk);
      if (in_ready) cnt++;
      guard++;
      @(posedge clk); #1;
      round_en = 1'($urandom_range(0, 1));
    end
    if (cnt < 65536) fail("stream_timeout");
    drain();
    @(negedge clk);
    chk("sat_count_full", sat_count, 16'hFFFF);
    @(posedge clk); #1;
    send_expect("sat_sticky", 32'hFF000000, 1'b0, 16'h8000, 1'b1);
    @(negedge clk);
    chk("sat_count_stuck", sat_count, 16'hFFFF);
    @(posedge clk); #1;

    // Clear colliding with a saturated output transfer.
    out_ready = 1'b0;
    send(32'h01000000, 1'b0);
    got = 0;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) fail("clr_wait_timeout");
    @(posedge clk); #1 out_ready = 1'b1; clr_count = 1'b1;
    @(posedge clk); #1 clr_count = 1'b0;
    @(negedge clk);
    chk("clr_wins", sat_count, 0);
    @(posedge clk); #1;

    // Reset with two samples in flight.
    send_expect("pre_reset_sat", 32'h01000000, 1'b0, 16'h7FFF, 1'b1);
    out_ready = 1'b0;
    send(32'h01000000, 1'b0);
    send(32'h00001200, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      chk("no_output_after_reset", out_valid, 0);
    end
    chk("sat_count_after_reset", sat_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    fail("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
